piso_serializer: RTL and testbench

//   Parallel-in, serial-out transmitter; the sending end for our serial shift-register links.

---
 rtl/ser_pkg.sv | 18 +
 rtl/ser_bit_counter.sv | 30 +++
 rtl/piso_serializer.sv | 112 +++++++++++
 tb/tb_piso_serializer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// Shared definitions for the serial shift-register link: state
// encoding for the transmit/receive FSMs and the bit-counter width.
package ser_pkg;

    localparam logic ST_IDLE_ENC  = 1'b0;
    localparam logic ST_SHIFT_ENC = 1'b1;

    typedef enum logic {
        IDLE  = ST_IDLE_ENC,
        SHIFT = ST_SHIFT_ENC
    } ser_state_t;

    // Bits needed to count down from width-1 to 0.
    function automatic int CNT_W(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Down-counter that tracks how many bits of the current word remain.
// It loads a start value, decrements when enabled and stops at zero,
// so it can never wrap.
module ser_bit_counter #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    input  logic          enable,
    output logic          zero
);

    logic [CW-1:0] count;

    // Load has priority over decrement; the count holds once it hits zero.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter. A word accepted on the
// valid/ready handshake is sent one bit per clock on sout, framed by
// sout_valid. A new word can be accepted during the last bit of the
// previous one, so consecutive words stream without a gap.
module piso_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter bit MSB_FIRST  = 1'b0,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int            CW       = CNT_W(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    ser_state_t       state;
    ser_state_t       next_state;
    logic [WIDTH-1:0] shift_reg;
    logic             started;
    logic             last_bit;
    logic             accept;
    logic             out_bit;

    assign accept  = load_valid & load_ready;
    assign out_bit = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];

    ser_bit_counter #(
        .CW(CW)
    ) u_bit_counter (
        .clk       (clk),
        .clr       (clr),
        .load      (accept),
        .load_value(LAST_IDX),
        .enable    (state == SHIFT),
        .zero      (last_bit)
    );

    // Holds load_ready low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            started <= 1'b0;
        end else begin
            started <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Latches the word on accept, otherwise moves the next bit to the output end.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            shift_reg <= '0;
        end else if (accept) begin
            shift_reg <= load_data;
        end else if (state == SHIFT) begin
            if (MSB_FIRST) begin
                shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
            end else begin
                shift_reg <= {1'b0, shift_reg[WIDTH-1:1]};
            end
        end
    end

    // Next-state logic and output decode, all from registered state.
    always_comb begin
        next_state = state;
        sout       = IDLE_LEVEL;
        sout_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        load_ready = 1'b0;
        case (state)
            IDLE: begin
                load_ready = started;
                if (accept) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                sout       = out_bit;
                sout_valid = 1'b1;
                busy       = 1'b1;
                done       = last_bit;
                load_ready = last_bit;
                if (last_bit && !accept) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: an LSB-first and an MSB-first
// instance share one set of inputs and are compared every cycle against
// a queue-based model of the bits still to be sent.
module tb_piso_serializer;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             clr;
    logic [WIDTH-1:0] load_data;
    logic             load_valid;

    logic load_ready_a, sout_a, sout_valid_a, busy_a, done_a;
    logic load_ready_b, sout_b, sout_valid_b, busy_b, done_b;

    int checks = 0;
    int errors = 0;

    bit   qa[$];
    bit   qb[$];
    bit   ready_ok;
    logic last_sout_a, last_sout_b, last_valid_a, last_ready_a;
    logic [WIDTH-1:0] chain = '0;

    typedef struct {
        logic [3:0] word;
        logic [3:0] seq_lsb;
        logic [3:0] seq_msb;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_a (
        .clk(clk), .clr(clr), .load_data(load_data), .load_valid(load_valid),
        .load_ready(load_ready_a), .sout(sout_a), .sout_valid(sout_valid_a),
        .busy(busy_a), .done(done_a)
    );

    piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_b (
        .clk(clk), .clr(clr), .load_data(load_data), .load_valid(load_valid),
        .load_ready(load_ready_b), .sout(sout_b), .sout_valid(sout_valid_b),
        .busy(busy_b), .done(done_b)
    );

    // Receiving shift chain fed by the LSB-first link.
    always @(posedge clk) begin
        if (sout_valid_a) chain <= {sout_a, chain[WIDTH-1:1]};
    end

    function automatic void check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void check_vec(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic model_ready();
        return ready_ok && (qa.size() <= 1);
    endfunction

    task automatic check_output();
        logic ev, ea, eb;
        ev = (qa.size() != 0);
        ea = 1'b0;
        eb = 1'b0;
        if (ev) begin
            ea = qa[0];
            eb = qb[0];
        end
        check1("sout_a",       sout_a,       ea);
        check1("sout_valid_a", sout_valid_a, ev);
        check1("busy_a",       busy_a,       ev);
        check1("done_a",       done_a,       qa.size() == 1);
        check1("load_ready_a", load_ready_a, model_ready());
        check1("sout_b",       sout_b,       eb);
        check1("sout_valid_b", sout_valid_b, ev);
        check1("busy_b",       busy_b,       ev);
        check1("done_b",       done_b,       qb.size() == 1);
        check1("load_ready_b", load_ready_b, model_ready());
        last_sout_a  = sout_a;
        last_sout_b  = sout_b;
        last_valid_a = sout_valid_a;
        last_ready_a = load_ready_a;
    endtask

    // One clock cycle: drive at the falling edge, check, then advance the model at the rising edge.
    task automatic apply_stimulus(input logic v, input logic [WIDTH-1:0] d, input logic c);
        logic acc;
        load_valid = v;
        load_data  = d;
        clr        = c;
        if (!c) begin
            qa.delete();
            qb.delete();
            ready_ok = 1'b0;
        end
        #1;
        check_output();
        @(posedge clk);
        if (c) begin
            acc = v && model_ready();
            if (qa.size() != 0) begin
                void'(qa.pop_front());
                void'(qb.pop_front());
            end
            if (acc) begin
                for (int i = 0; i < WIDTH; i++) begin
                    qa.push_back(d[i]);
                    qb.push_back(d[WIDTH-1-i]);
                end
            end
            ready_ok = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] got_a, got_b;
        logic [7:0] cap;
        logic       busy_seen_low;

        vecs[0] = '{4'b1011, 4'b1011, 4'b1101};
        vecs[1] = '{4'b0001, 4'b0001, 4'b1000};
        vecs[2] = '{4'b0110, 4'b0110, 4'b0110};
        vecs[3] = '{4'b1000, 4'b1000, 4'b0001};
        vecs[4] = '{4'b0101, 4'b0101, 4'b1010};
        vecs[5] = '{4'b1110, 4'b1110, 4'b0111};

        clr        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        ready_ok   = 1'b0;
        #1 clr = 1'b0;
        @(negedge clk);

        // Reset with load_valid high: nothing accepted, outputs at reset values.
        apply_stimulus(1'b1, 4'b1011, 1'b0);
        apply_stimulus(1'b1, 4'b1011, 1'b0);
        apply_stimulus(1'b0, 4'b0000, 1'b1);
        apply_stimulus(1'b0, 4'b0000, 1'b1);

        // Single words from the table, both bit orders, plus loopback.
        foreach (vecs[n]) begin
            apply_stimulus(1'b1, vecs[n].word, 1'b1);
            for (int k = 0; k < WIDTH; k++) begin
                apply_stimulus(1'b0, 4'($urandom), 1'b1);
                got_a[k] = last_sout_a;
                got_b[k] = last_sout_b;
            end
            check_vec("table_lsb_bits", {4'b0, got_a}, {4'b0, vecs[n].seq_lsb});
            check_vec("table_msb_bits", {4'b0, got_b}, {4'b0, vecs[n].seq_msb});
            check_vec("loopback_word",  {4'b0, chain}, {4'b0, vecs[n].word});
            apply_stimulus(1'b0, 4'b0000, 1'b1);
        end

        // Back-to-back words: second accepted on the done cycle, busy stays high.
        busy_seen_low = 1'b0;
        apply_stimulus(1'b1, 4'b0001, 1'b1);
        for (int k = 0; k < 8; k++) begin
            apply_stimulus((k < 4) ? 1'b1 : 1'b0, 4'b1110, 1'b1);
            cap[k] = last_sout_a;
            if (!last_valid_a) busy_seen_low = 1'b1;
        end
        check_vec("b2b_bits", cap, 8'b1110_0001);
        check1("b2b_no_gap", busy_seen_low, 1'b0);
        apply_stimulus(1'b0, 4'b0000, 1'b1);

        // Backpressure: second word waits for the done cycle; first word unaffected.
        apply_stimulus(1'b1, 4'b1011, 1'b1);
        for (int k = 0; k < 8; k++) begin
            if (k == 0)      apply_stimulus(1'b0, 4'b1011, 1'b1);
            else if (k <= 3) apply_stimulus(1'b1, 4'b0110, 1'b1);
            else             apply_stimulus(1'b0, 4'($urandom), 1'b1);
            cap[k] = last_sout_a;
            if (k == 1) check1("bp_ready_count2", last_ready_a, 1'b0);
        end
        check_vec("bp_bits", cap, 8'b0110_1011);
        apply_stimulus(1'b0, 4'b0000, 1'b1);

        // Abort during bit 2, then a clean word after release.
        apply_stimulus(1'b1, 4'b1011, 1'b1);
        apply_stimulus(1'b0, 4'b1011, 1'b1);
        apply_stimulus(1'b0, 4'b1011, 1'b0);
        check1("abort_valid", last_valid_a, 1'b0);
        apply_stimulus(1'b1, 4'b0101, 1'b0);
        apply_stimulus(1'b1, 4'b0101, 1'b1);
        apply_stimulus(1'b1, 4'b0101, 1'b1);
        for (int k = 0; k < WIDTH; k++) begin
            apply_stimulus(1'b0, 4'($urandom), 1'b1);
            got_a[k] = last_sout_a;
        end
        check_vec("abort_resume_bits", {4'b0, got_a}, 8'b0000_0101);
        apply_stimulus(1'b0, 4'b0000, 1'b1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            apply_stimulus(($urandom % 3) != 0, 4'($urandom), ($urandom % 50) != 0);
        end
        apply_stimulus(1'b0, 4'b0000, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
